ftoi_arb: RTL

FTOI_ARB -- requirements
Module: ftoi_arb

---
 rtl/ftoi_pkg.sv | 12 +
 rtl/ftoi_arb_if.sv | 23 ++
 rtl/ftoi_core.sv | 26 ++
 rtl/ftoi_arb.sv | 69 ++++++
 4 files changed

// File: rtl/ftoi_pkg.sv
// Shared types and constants for the float-to-int arbiter slice.
package ftoi_pkg;
  localparam int FTOI_BIAS_SHIFT   = 158;
  localparam int FTOI_ZERO_EXP_MAX = 126;
  localparam int NREQ              = 2;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } float_t;
endpackage

// File: rtl/ftoi_arb_if.sv
// Per-requester request/result channels of the shared float-to-int converter.
// Handshake: a request transfers when in_valid[i] && in_ready[i] on a rising edge;
// a result transfers when out_valid[i] && out_ready[i]. out_ready is ignored while out_valid is 0.
interface ftoi_arb_if;
  import ftoi_pkg::*;

  logic [NREQ-1:0]       in_valid;
  logic [NREQ-1:0][31:0] in_x;
  logic [NREQ-1:0]       in_ready;
  logic [NREQ-1:0]       out_valid;
  logic [NREQ-1:0][31:0] out_y;
  logic [NREQ-1:0]       out_ready;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/ftoi_core.sv
// Combinational IEEE-754 single to signed 32-bit integer, truncating toward zero.
module ftoi_core
  import ftoi_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);
  float_t     f;
  logic [7:0] sh_full;
  logic [31:0] mag;

  assign f = float_t'(x);

  // Shift amount wraps modulo 32 for large exponents; no saturation by design.
  always_comb begin
    sh_full = 8'(FTOI_BIAS_SHIFT) - f.e;
    mag     = {1'b1, f.m, 8'b0} >> sh_full[4:0];
    if (f.e <= 8'(FTOI_ZERO_EXP_MAX)) begin
      y = '0;
    end else if (f.s) begin
      y = ~mag + 32'd1;
    end else begin
      y = mag;
    end
  end
endmodule

// File: rtl/ftoi_arb.sv
// Two requesters share one float-to-int converter; round-robin on ties, one-cycle result latency.
module ftoi_arb
  import ftoi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  ftoi_arb_if.slave        bus,
  output logic [CNT_W-1:0] conv_count
);
  logic                  last_grant;
  logic [NREQ-1:0]       elig;
  logic                  grant_any;
  logic                  grant_idx;
  logic [31:0]           core_y;
  logic [NREQ-1:0]       out_valid_q;
  logic [NREQ-1:0][31:0] out_y_q;

  // A port may accept when its result slot is empty or being drained this cycle.
  always_comb begin
    elig      = bus.in_valid & (~out_valid_q | bus.out_ready);
    grant_any = |elig;
    if (elig == 2'b11) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = elig[1];
    end
    bus.in_ready = '0;
    if (grant_any && !rst) begin
      bus.in_ready[grant_idx] = 1'b1;
    end
  end

  ftoi_core u_core (
    .x (bus.in_x[grant_idx]),
    .y (core_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      conv_count <= '0;
    end else if (grant_any) begin
      last_grant <= grant_idx;
      conv_count <= conv_count + CNT_W'(1);
    end
  end

  // Accept wins over consume so a port can stream one result per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_y_q     <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.in_ready[i]) begin
          out_valid_q[i] <= 1'b1;
          out_y_q[i]     <= core_y;
        end else if (bus.out_ready[i]) begin
          out_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
endmodule
